hazard5_bus_arbiter: RTL

- Shares one AHB-Lite master port between the instruction fetch port (frontend) and the load/store port (execute stage).
- Tracks address-phase and data-phase ownership separately, so each requester sees its own rdy/data_vld handshake.
- Back-to-back pipelined transfers from either requester run at full bus rate.
- Sits between the core's frontend/LSU and the system bus.

---
 rtl/hazard5_bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hazard5_bus_arbiter.sv
// hazard5_bus_arbiter: shares one AHB-Lite master port between the
// instruction fetch port (I) and the load/store port (D).
// Address-phase and data-phase ownership are tracked separately, so a new
// address phase from one requester can overlap the data phase of the other.
// Optional macro HAZARD5_ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority
// with alternating priority when both ports request together.

module hazard5_bus_arbiter #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic [W_ADDR-1:0] i_addr,
   input  logic              i_size,
   input  logic              i_addr_vld,
   output logic              i_addr_rdy,
   output logic [W_DATA-1:0] i_data,
   output logic              i_data_vld,

   input  logic [W_ADDR-1:0] d_addr,
   input  logic [1:0]        d_size,
   input  logic              d_write,
   input  logic [W_DATA-1:0] d_wdata,
   input  logic              d_addr_vld,
   output logic              d_addr_rdy,
   output logic [W_DATA-1:0] d_rdata,
   output logic              d_data_vld,

   output logic [W_ADDR-1:0] ahblm_haddr,
   output logic [1:0]        ahblm_htrans,
   output logic              ahblm_hwrite,
   output logic [2:0]        ahblm_hsize,
   input  logic              ahblm_hready,
   output logic [W_DATA-1:0] ahblm_hwdata,
   input  logic [W_DATA-1:0] ahblm_hrdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   owner_t              grant;
   owner_t              aph_owner;
   owner_t              dph_owner;
   logic                aph_hold;
   logic [W_DATA-1:0]   hwdata_q;

`ifdef HAZARD5_ARB_ROUND_ROBIN_EN
   logic                last_d;

   // Remember who won the last accepted address phase so ties alternate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d <= 1'b0;
      end else if (ahblm_hready && grant != OWN_NONE) begin
         last_d <= (grant == OWN_D);
      end
   end
`endif

   // Address-phase grant: a stalled address keeps its owner, otherwise arbitrate
   always_comb begin
      grant = OWN_NONE;
      if (aph_hold) begin
         grant = aph_owner;
`ifdef HAZARD5_ARB_ROUND_ROBIN_EN
      end else if (d_addr_vld && i_addr_vld) begin
         grant = last_d ? OWN_I : OWN_D;
`endif
      end else if (d_addr_vld) begin
         grant = OWN_D;
      end else if (i_addr_vld) begin
         grant = OWN_I;
      end
   end

   // Bus address-phase signals muxed from the granted port
   always_comb begin
      ahblm_htrans = HTRANS_IDLE;
      ahblm_haddr  = '0;
      ahblm_hwrite = 1'b0;
      ahblm_hsize  = 3'b000;
      case (grant)
         OWN_I: begin
            ahblm_htrans = HTRANS_NONSEQ;
            ahblm_haddr  = i_addr;
            ahblm_hsize  = i_size ? 3'b010 : 3'b001;
         end
         OWN_D: begin
            ahblm_htrans = HTRANS_NONSEQ;
            ahblm_haddr  = d_addr;
            ahblm_hwrite = d_write;
            ahblm_hsize  = {1'b0, d_size};
         end
         default: begin
         end
      endcase
   end

   // Hold the address-phase owner across hready-low stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aph_hold  <= 1'b0;
         aph_owner <= OWN_NONE;
      end else begin
         aph_hold  <= (grant != OWN_NONE) && !ahblm_hready;
         aph_owner <= grant;
      end
   end

   // Advance data-phase ownership and capture store data when the bus moves on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dph_owner <= OWN_NONE;
         hwdata_q  <= '0;
      end else if (ahblm_hready) begin
         dph_owner <= grant;
         if (grant == OWN_D && d_write) begin
            hwdata_q <= d_wdata;
         end
      end
   end

   // Per-requester handshakes derived from grant/data-phase owner and hready
   always_comb begin
      i_addr_rdy   = ahblm_hready && (grant == OWN_I);
      d_addr_rdy   = ahblm_hready && (grant == OWN_D);
      i_data_vld   = ahblm_hready && (dph_owner == OWN_I);
      d_data_vld   = ahblm_hready && (dph_owner == OWN_D);
      i_data       = ahblm_hrdata;
      d_rdata      = ahblm_hrdata;
      ahblm_hwdata = hwdata_q;
   end

   // A requester must keep its request up while its address is stalled
   held_owner_vld: assert property (
      @(posedge clk) disable iff (!rst_n)
      aph_hold |-> ((aph_owner == OWN_I) ? i_addr_vld :
                    (aph_owner == OWN_D) ? d_addr_vld : 1'b0)
   );

endmodule
